// File: rtl/aes_inv_sbox_word_unit.sv
// Byte-serial AES InvSubBytes engine.
// A word is accepted over in_valid/in_ready, then one byte per clock is pushed
// through a single composite-field GF((2^4)^2) inverse S-box. The finished word
// is offered over out_valid/out_ready.
// Tower field: GF(2^4) uses x^4 + x + 1; GF((2^4)^2) uses y^2 + y + lambda with
// lambda = 0xC. The isomorphism sends the AES element 0x02 to the composite root
// 0x21 of the AES polynomial, so column i of the map is 0x21^i.
module aes_inv_sbox_word_unit #(
    parameter int N_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*N_BYTES-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*N_BYTES-1:0]   out_data,
    output logic                   busy
);

    localparam int CW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(N_BYTES - 1);

    // Column i is the composite-field image of AES basis element 2^i.
    localparam logic [63:0] ISO_COLS =
        {8'hE2, 8'h3C, 8'hDA, 8'h34, 8'h4E, 8'h44, 8'h21, 8'h01};
    // Column j is the AES-field image of composite basis bit j.
    localparam logic [63:0] INV_ISO_COLS =
        {8'h3B, 8'hE4, 8'h03, 8'hF3, 8'h50, 8'hE0, 8'h5C, 8'h01};
    localparam logic [3:0] LAMBDA = 4'hC;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [8*N_BYTES-1:0]   work_q, work_d;
    logic [8*N_BYTES-1:0]   out_q, out_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic                   busy_q, busy_d;
    logic [7:0]             lane_in, lane_out;

    // GF(2^4) multiply, reduction by x^4 + x + 1.
    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] aa;
        p  = 4'h0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    // GF(2^4) squaring is linear, so it reduces to a few XORs.
    function automatic logic [3:0] gf16_sq(input logic [3:0] q);
        return {q[3], q[3] ^ q[1], q[2], q[2] ^ q[0]};
    endfunction

    // GF(2^4) inverse as q^14 = q^2 * q^4 * q^8; zero maps to zero.
    function automatic logic [3:0] gf16_inv(input logic [3:0] q);
        logic [3:0] q2, q4, q8;
        q2 = gf16_sq(q);
        q4 = gf16_sq(q2);
        q8 = gf16_sq(q4);
        return gf16_mul(gf16_mul(q2, q4), q8);
    endfunction

    // Linear map given as eight columns: XOR the columns selected by set bits.
    function automatic logic [7:0] lin_map(input logic [63:0] cols, input logic [7:0] v);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) r = r ^ cols[8*i +: 8];
        end
        return r;
    endfunction

    // Full inverse S-box: inverse affine, field inverse in the tower basis.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] a, c;
        logic [3:0] hi, lo, norm, norm_inv, hi_o, lo_o;
        a    = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        c    = lin_map(ISO_COLS, a);
        hi   = c[7:4];
        lo   = c[3:0];
        // Norm of (hi*y + lo): lambda*hi^2 + hi*lo + lo^2, an element of GF(2^4).
        norm     = gf16_mul(gf16_sq(hi), LAMBDA) ^ gf16_mul(hi, lo) ^ gf16_sq(lo);
        norm_inv = gf16_inv(norm);
        hi_o     = gf16_mul(hi, norm_inv);
        lo_o     = gf16_mul(hi ^ lo, norm_inv);
        return lin_map(INV_ISO_COLS, {hi_o, lo_o});
    endfunction

    // Next-state logic for the handshake FSM and the byte-serial datapath.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves
        // it unassigned and no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        out_d    = out_q;
        lane_in  = work_q[8*cnt_q +: 8];
        lane_out = inv_sbox(lane_in);
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    work_d  = in_data;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                out_d[8*cnt_q +: 8] = lane_out;
                if (cnt_q == LAST_LANE) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the work and result registers are plain flops, not a RAM, so
            // clearing them here is cheap and guarantees no stale data is shown.
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            out_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the values
            // from before this edge, independent of statement order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            out_q       <= out_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_aes_inv_sbox_word_unit.sv
// Self-checking bench for aes_inv_sbox_word_unit.
// Reference: the forward S-box is built from its definition (GF(2^8) inverse
// under x^8+x^4+x^3+x+1, then the forward affine with 0x63) and inverted as a
// table, so expected InvSubBytes values never depend on the DUT's arithmetic.
module tb_aes_inv_sbox_word_unit;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic          busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] sbox_t [256];
    logic [7:0] inv_t  [256];

    aes_inv_sbox_word_unit #(.N_BYTES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] x);
        if (x == 8'h00) return 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(x, 8'(y)) == 8'h01) return 8'(y);
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] w);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = inv_t[w[8*k +: 8]];
        return r;
    endfunction

    // Accept one word with in_valid pulsed, then wait for out_valid (bounded).
    task automatic send_word(input logic [31:0] w, input string tag);
        int n;
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, N);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] words [$];
        logic [31:0] w, hold, exp_q [$];
        int          n, cyc, last_acc, n_acc, n_out;
        logic        rdy_b, val_b;
        logic [31:0] dat_b;

        // Reference tables.
        for (int x = 0; x < 256; x++) begin
            logic [7:0] s;
            s = ginv(8'(x));
            sbox_t[x] = s ^ rotl(s, 1) ^ rotl(s, 2) ^ rotl(s, 3) ^ rotl(s, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_t[sbox_t[x]] = 8'(x);

        // Reset state.
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy",      {31'b0, busy},      32'd0);
        check("rst_out_data",  out_data,           32'h0);
        rst = 1'b0;
        tick();

        // Single word with exact latency and busy window.
        in_valid = 1'b1; in_data = 32'h7B777C63;
        tick();
        in_valid = 1'b0;
        check("t1_busy_e0",     {31'b0, busy},     32'd1);
        check("t1_in_ready_e0", {31'b0, in_ready}, 32'd0);
        for (int i = 1; i < N; i++) begin
            tick();
            check("t1_early_valid", {31'b0, out_valid}, 32'd0);
        end
        tick();
        check("t1_valid_e4", {31'b0, out_valid}, 32'd1);
        check("t1_data",     out_data,           32'h03020100);

        // Backpressure in DONE.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid",    {31'b0, out_valid}, 32'd1);
            check("bp_data",     out_data,           32'h03020100);
            check("bp_in_ready", {31'b0, in_ready},  32'd0);
            check("bp_busy",     {31'b0, busy},      32'd1);
        end
        drain();
        check("bp_exit_valid", {31'b0, out_valid}, 32'd0);
        check("bp_exit_ready", {31'b0, in_ready},  32'd1);
        check("bp_exit_busy",  {31'b0, busy},      32'd0);
        check("bp_idle_hold",  out_data,           32'h03020100);

        // Input ignored while busy; the held word is taken only in IDLE.
        w = $urandom;
        in_valid = 1'b1; in_data = w;
        tick();
        in_data = 32'hFFFFFFFF;
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        check("ib_latency", n, N);
        check("ib_data",    out_data, model_word(w));
        tick();
        check("ib_done_no_accept", out_data, model_word(w));
        drain();
        check("ib_idle_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        check("ib_second_latency", n, N);
        check("ib_second_data",    out_data, 32'h7D7D7D7D);
        check("ib_second_model",   out_data, model_word(32'hFFFFFFFF));
        drain();

        // Reset in the middle of BUSY.
        w = $urandom;
        in_valid = 1'b1; in_data = w;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        check("mr_out_valid", {31'b0, out_valid}, 32'd0);
        check("mr_out_data",  out_data,           32'h0);
        check("mr_in_ready",  {31'b0, in_ready},  32'd1);
        check("mr_busy",      {31'b0, busy},      32'd0);
        rst = 1'b0;
        tick();
        send_word(32'h00000000, "mr_new");
        check("mr_new_data", out_data, 32'h52525252);
        drain();

        // Random words, one at a time.
        for (int i = 0; i < 8; i++) begin
            w = $urandom;
            send_word(w, "rnd");
            check("rnd_data", out_data, model_word(w));
            drain();
        end

        // Exhaustive byte sweep plus random words, streamed back-to-back.
        for (int i = 0; i < 64; i++)
            words.push_back({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
        for (int i = 0; i < 16; i++) words.push_back($urandom);
        foreach (words[i]) exp_q.push_back(model_word(words[i]));

        n_acc = 0; n_out = 0; last_acc = 0; cyc = 0;
        in_valid = 1'b1; in_data = words[0]; out_ready = 1'b1;
        while (n_out < words.size() && cyc < 2000) begin
            rdy_b = in_ready;
            val_b = out_valid;
            dat_b = out_data;
            tick();
            cyc++;
            if (rdy_b && in_valid) begin
                if (n_acc > 0) check("bb_interval", cyc - last_acc, N + 2);
                last_acc = cyc;
                n_acc++;
                if (n_acc < words.size()) in_data = words[n_acc];
                else in_valid = 1'b0;
            end
            if (val_b) begin
                hold = exp_q.pop_front();
                check("bb_data", dat_b, hold);
                n_out++;
            end
        end
        check("bb_outputs", n_out, words.size());
        check("bb_accepts", n_acc, words.size());
        in_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        check("bb_final_idle", {31'b0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
